// File: rtl/ysyx_23060203_mem_arb.sv
// Two-requester memory arbiter for the IFU and LSU.
// One transaction is in flight at a time. Each transaction goes through
// IDLE -> ACCESS -> RESP. ACCESS waits LAT cycles, then drives the memory
// port for a single cycle. Requests are granted round-robin, and the LSU
// goes first after reset.
module ysyx_23060203_mem_arb #(
    parameter int unsigned LAT = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [2:0]  lsu_func,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,

    output logic        mem_ren,
    output logic [2:0]  mem_rfunc,
    output logic [31:0] mem_raddr,
    output logic        mem_wen,
    output logic [2:0]  mem_wfunc,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] IFU_FUNC = 3'b010;  // instruction fetch is always a word

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        owner_lsu_reg;   // 1: the transaction in flight belongs to the LSU
    logic [31:0] addr_reg;
    logic        wen_reg;
    logic [2:0]  func_reg;
    logic [31:0] wdata_reg;
    logic [31:0] resp_reg;
    logic        last_lsu_reg;    // 1: the LSU won the most recently completed transaction

    logic grant_lsu;
    logic grant_ifu;
    logic idle_open;
    logic access_cycle;
    logic in_resp;
    logic resp_ready_sel;

    // Grant and handshake decode. Ready is held low while reset is asserted.
    always_comb begin
        grant_lsu      = lsu_req_valid && (!ifu_req_valid || !last_lsu_reg);
        grant_ifu      = ifu_req_valid && !grant_lsu;
        idle_open      = (state_reg == IDLE) && !rst;
        access_cycle   = (state_reg == ACCESS) && (cnt_reg == 4'd0);
        in_resp        = (state_reg == RESP);
        resp_ready_sel = owner_lsu_reg ? lsu_resp_ready : ifu_resp_ready;
    end

    assign lsu_req_ready  = idle_open && grant_lsu;
    assign ifu_req_ready  = idle_open && grant_ifu;

    // The memory port is driven only during the access cycle. It is zero at all other times.
    assign mem_ren   = access_cycle && !wen_reg;
    assign mem_raddr = mem_ren ? addr_reg : 32'd0;
    assign mem_rfunc = mem_ren ? func_reg : 3'd0;
    assign mem_wen   = access_cycle && wen_reg;
    assign mem_waddr = mem_wen ? addr_reg : 32'd0;
    assign mem_wfunc = mem_wen ? func_reg : 3'd0;
    assign mem_wdata = mem_wen ? wdata_reg : 32'd0;

    // Only the owner of the transaction sees the response. The other requester reads zero.
    assign lsu_resp_valid = in_resp && owner_lsu_reg;
    assign ifu_resp_valid = in_resp && !owner_lsu_reg;
    assign lsu_rdata      = lsu_resp_valid ? resp_reg : 32'd0;
    assign ifu_rdata      = ifu_resp_valid ? resp_reg : 32'd0;

    // Transaction FSM: latch the request, wait, access memory, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            owner_lsu_reg <= 1'b0;
            addr_reg      <= 32'd0;
            wen_reg       <= 1'b0;
            func_reg      <= 3'd0;
            wdata_reg     <= 32'd0;
            resp_reg      <= 32'd0;
            last_lsu_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_lsu || grant_ifu) begin
                        owner_lsu_reg <= grant_lsu;
                        addr_reg      <= grant_lsu ? lsu_addr : ifu_addr;
                        wen_reg       <= grant_lsu && lsu_wen;
                        func_reg      <= grant_lsu ? lsu_func : IFU_FUNC;
                        wdata_reg     <= grant_lsu ? lsu_wdata : 32'd0;
                        cnt_reg       <= 4'(LAT);
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        resp_reg  <= wen_reg ? 32'd0 : mem_rdata;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_sel) begin
                        last_lsu_reg <= owner_lsu_reg;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_mem_arb.sv
// Directed testbench for ysyx_23060203_mem_arb.
// Instance 0 uses LAT=0, instance 1 uses LAT=3 and instance 2 uses LAT=2.
// The instances share their request inputs. Each one has its own reset, so
// the instances that a test does not exercise are held in reset.
module tb_ysyx_23060203_mem_arb;

    logic        clk = 1'b0;
    logic [2:0]  rst;

    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        ifu_resp_ready;
    logic        lsu_req_valid;
    logic        lsu_wen;
    logic [2:0]  lsu_func;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_resp_ready;

    logic [2:0]  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid, mem_ren, mem_wen;
    logic [31:0] ifu_rdata [3];
    logic [31:0] lsu_rdata [3];
    logic [31:0] mem_raddr [3];
    logic [31:0] mem_waddr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic [2:0]  mem_rfunc [3];
    logic [2:0]  mem_wfunc [3];

    int errors = 0;
    int checks = 0;

    // Combinational memory contents: the boot word lives at 0x80000000.
    // Every other address returns a fixed scramble of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
    endfunction

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned L = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
        ysyx_23060203_mem_arb #(.LAT(L)) dut (
            .clk(clk), .rst(rst[gi]),
            .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready[gi]),
            .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid[gi]),
            .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata[gi]),
            .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready[gi]),
            .lsu_wen(lsu_wen), .lsu_func(lsu_func), .lsu_addr(lsu_addr),
            .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid[gi]),
            .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata[gi]),
            .mem_ren(mem_ren[gi]), .mem_rfunc(mem_rfunc[gi]), .mem_raddr(mem_raddr[gi]),
            .mem_wen(mem_wen[gi]), .mem_wfunc(mem_wfunc[gi]), .mem_waddr(mem_waddr[gi]),
            .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi])
        );
        assign mem_rdata[gi] = memf(mem_raddr[gi]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_inputs;
        ifu_req_valid  = 1'b0;
        ifu_addr       = 32'd0;
        ifu_resp_ready = 1'b1;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;
        lsu_func       = 3'd0;
        lsu_addr       = 32'd0;
        lsu_wdata      = 32'd0;
        lsu_resp_ready = 1'b1;
    endtask

    // Reset every instance, then release only instance k.
    task automatic start(input int k);
        rst = 3'b111;
        clear_inputs();
        tick();
        tick();
        rst[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 3'b111;
        clear_inputs();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0004;
        tick();
        settle();
        checks++;
        if ({ifu_req_ready[0], lsu_req_ready[0]} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", {ifu_req_ready[0], lsu_req_ready[0]});
        end
        checks++;
        if ({mem_ren[0], mem_wen[0], ifu_resp_valid[0], lsu_resp_valid[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_enables: got %b expected 0000",
                     {mem_ren[0], mem_wen[0], ifu_resp_valid[0], lsu_resp_valid[0]});
        end
        checks++;
        if ((mem_raddr[0] | mem_waddr[0] | mem_wdata[0] | ifu_rdata[0] | lsu_rdata[0]) !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0",
                     mem_raddr[0] | mem_waddr[0] | mem_wdata[0] | ifu_rdata[0] | lsu_rdata[0]);
        end
        rst[0] = 1'b0;
        settle();
        checks++;
        if ({lsu_req_ready[0], ifu_req_ready[0]} !== 2'b10) begin
            errors++;
            $display("FAIL reset_lsu_first: got %b expected 10", {lsu_req_ready[0], ifu_req_ready[0]});
        end
        $display("reset: readies=%b", {lsu_req_ready[0], ifu_req_ready[0]});
        clear_inputs();
    endtask

    task automatic test_ifu_read;
        start(0);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        settle();
        checks++;
        if (ifu_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ifu_ready: got %b expected 1", ifu_req_ready[0]);
        end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'hDEAD_BEEC;
        settle();
        checks++;
        if ({mem_ren[0], mem_wen[0], mem_raddr[0], mem_rfunc[0]} !== {2'b10, 32'h8000_0000, 3'b010}) begin
            errors++;
            $display("FAIL ifu_access: got ren=%b wen=%b addr=%h func=%b expected 1 0 80000000 010",
                     mem_ren[0], mem_wen[0], mem_raddr[0], mem_rfunc[0]);
        end
        checks++;
        if (ifu_resp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ifu_early_resp: got %b expected 0", ifu_resp_valid[0]);
        end
        tick();
        settle();
        checks++;
        if ({ifu_resp_valid[0], lsu_resp_valid[0], mem_ren[0]} !== 3'b100 || ifu_rdata[0] !== 32'h0000_0413) begin
            errors++;
            $display("FAIL ifu_resp: got v=%b lv=%b ren=%b data=%h expected 1 0 0 00000413",
                     ifu_resp_valid[0], lsu_resp_valid[0], mem_ren[0], ifu_rdata[0]);
        end
        tick();
        lsu_req_valid = 1'b1;
        settle();
        checks++;
        if (ifu_resp_valid[0] !== 1'b0 || ifu_rdata[0] !== 32'd0 || lsu_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ifu_back_idle: got v=%b data=%h lrdy=%b expected 0 0 1",
                     ifu_resp_valid[0], ifu_rdata[0], lsu_req_ready[0]);
        end
        $display("ifu_read: data=%h", 32'h0000_0413);
        clear_inputs();
    endtask

    task automatic test_round_robin;
        logic exp_lsu;
        start(0);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0020;
        lsu_func      = 3'b100;
        settle();
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2 == 0);
            checks++;
            if ({lsu_req_ready[0], ifu_req_ready[0]} !== {exp_lsu, !exp_lsu}) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", i,
                         {lsu_req_ready[0], ifu_req_ready[0]}, {exp_lsu, !exp_lsu});
            end
            tick();
            settle();
            checks++;
            if (mem_rfunc[0] !== (exp_lsu ? 3'b100 : 3'b010)) begin
                errors++;
                $display("FAIL rr_func%0d: got %b expected %b", i, mem_rfunc[0],
                         exp_lsu ? 3'b100 : 3'b010);
            end
            tick();
            settle();
            checks++;
            if ({lsu_resp_valid[0], ifu_resp_valid[0]} !== {exp_lsu, !exp_lsu} ||
                (exp_lsu ? lsu_rdata[0] : ifu_rdata[0]) !== memf(exp_lsu ? lsu_addr : ifu_addr)) begin
                errors++;
                $display("FAIL rr_resp%0d: got v=%b data=%h expected v=%b data=%h", i,
                         {lsu_resp_valid[0], ifu_resp_valid[0]},
                         exp_lsu ? lsu_rdata[0] : ifu_rdata[0], {exp_lsu, !exp_lsu},
                         memf(exp_lsu ? lsu_addr : ifu_addr));
            end
            $display("round_robin %0d: winner=%s", i, exp_lsu ? "lsu" : "ifu");
            tick();
            settle();
        end
        clear_inputs();
    endtask

    task automatic test_store;
        int wcnt = 0;
        int rcnt = 0;
        int respcnt = 0;
        logic [31:0] waddr = 32'd0;
        logic [31:0] wdata = 32'd0;
        logic [2:0]  wfunc = 3'd7;
        logic [31:0] rdata = 32'hFFFF_FFFF;
        start(0);
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_func      = 3'b000;
        lsu_addr      = 32'h8000_0100;
        lsu_wdata     = 32'h0000_00A5;
        settle();
        checks++;
        if (lsu_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL store_ready: got %b expected 1", lsu_req_ready[0]);
        end
        tick();
        lsu_req_valid = 1'b0;
        lsu_wdata     = 32'hFFFF_FFFF;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (mem_wen[0]) begin
                wcnt++;
                waddr = mem_waddr[0];
                wdata = mem_wdata[0];
                wfunc = mem_wfunc[0];
            end
            if (mem_ren[0]) rcnt++;
            if (lsu_resp_valid[0]) begin
                respcnt++;
                rdata = lsu_rdata[0];
            end
            tick();
        end
        checks++;
        if (wcnt !== 1 || rcnt !== 0) begin
            errors++;
            $display("FAIL store_wen_count: got wen=%0d ren=%0d expected 1 0", wcnt, rcnt);
        end
        checks++;
        if ({waddr, wdata, wfunc} !== {32'h8000_0100, 32'h0000_00A5, 3'b000}) begin
            errors++;
            $display("FAIL store_fields: got %h %h %b expected 80000100 000000a5 000", waddr, wdata, wfunc);
        end
        checks++;
        if (respcnt !== 1 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL store_resp: got count=%0d data=%h expected 1 0", respcnt, rdata);
        end
        $display("store: wen_cycles=%0d resp=%0d", wcnt, respcnt);
        clear_inputs();
    endtask

    task automatic test_latency3;
        start(1);
        lsu_req_valid = 1'b1;
        lsu_func      = 3'b010;
        lsu_addr      = 32'h8000_0200;
        settle();
        checks++;
        if (lsu_req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL lat3_ready: got %b expected 1", lsu_req_ready[1]);
        end
        tick();
        lsu_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            settle();
            checks++;
            if ({mem_ren[1], mem_wen[1]} !== {(k == 4), 1'b0}) begin
                errors++;
                $display("FAIL lat3_en_c%0d: got %b expected %b", k, {mem_ren[1], mem_wen[1]}, {(k == 4), 1'b0});
            end
            checks++;
            if (lsu_resp_valid[1] !== (k == 5)) begin
                errors++;
                $display("FAIL lat3_resp_c%0d: got %b expected %b", k, lsu_resp_valid[1], (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (lsu_rdata[1] !== memf(32'h8000_0200)) begin
                    errors++;
                    $display("FAIL lat3_data: got %h expected %h", lsu_rdata[1], memf(32'h8000_0200));
                end
            end
            tick();
        end
        $display("latency3: access at accept+4, resp at accept+5");
        clear_inputs();
    endtask

    task automatic test_back_pressure;
        start(0);
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0040;
        ifu_resp_ready = 1'b0;
        settle();
        checks++;
        if (ifu_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready: got %b expected 1", ifu_req_ready[0]);
        end
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0050;
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++;
            if (ifu_resp_valid[0] !== 1'b1 || ifu_rdata[0] !== memf(32'h8000_0040)) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b data=%h expected 1 %h", k,
                         ifu_resp_valid[0], ifu_rdata[0], memf(32'h8000_0040));
            end
            checks++;
            if ({ifu_req_ready[0], lsu_req_ready[0]} !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready%0d: got %b expected 00", k, {ifu_req_ready[0], lsu_req_ready[0]});
            end
            ifu_addr = ifu_addr + 32'h44;
            tick();
        end
        ifu_resp_ready = 1'b1;
        settle();
        checks++;
        if (ifu_resp_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got %b expected 1", ifu_resp_valid[0]);
        end
        tick();
        settle();
        checks++;
        if (ifu_resp_valid[0] !== 1'b0 || lsu_req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_after: got v=%b lrdy=%b expected 0 1", ifu_resp_valid[0], lsu_req_ready[0]);
        end
        $display("back_pressure: held 5 cycles");
        clear_inputs();
    endtask

    task automatic test_reset_abort;
        int wcnt = 0;
        int respcnt = 0;
        start(2);
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0060;
        settle();
        checks++;
        if (lsu_req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_first_ready: got %b expected 1", lsu_req_ready[2]);
        end
        tick();
        lsu_req_valid = 1'b0;
        repeat (4) tick();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        settle();
        checks++;
        if ({lsu_req_ready[2], ifu_req_ready[2]} !== 2'b01) begin
            errors++;
            $display("FAIL abort_ifu_turn: got %b expected 01", {lsu_req_ready[2], ifu_req_ready[2]});
        end
        ifu_req_valid = 1'b0;
        lsu_wen       = 1'b1;
        lsu_func      = 3'b001;
        lsu_addr      = 32'h8000_0300;
        lsu_wdata     = 32'h0000_1234;
        settle();
        checks++;
        if (lsu_req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_store_ready: got %b expected 1", lsu_req_ready[2]);
        end
        tick();
        lsu_req_valid = 1'b0;
        settle();
        checks++;
        if (mem_wen[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_wen: got %b expected 0", mem_wen[2]);
        end
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (mem_wen[2]) wcnt++;
            if (lsu_resp_valid[2] || ifu_resp_valid[2]) respcnt++;
            tick();
        end
        checks++;
        if (wcnt !== 0 || respcnt !== 0) begin
            errors++;
            $display("FAIL abort_quiet: got wen=%0d resp=%0d expected 0 0", wcnt, respcnt);
        end
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        settle();
        checks++;
        if ({lsu_req_ready[2], ifu_req_ready[2]} !== 2'b10) begin
            errors++;
            $display("FAIL abort_lsu_first: got %b expected 10", {lsu_req_ready[2], ifu_req_ready[2]});
        end
        $display("reset_abort: wen=%0d resp=%0d", wcnt, respcnt);
        clear_inputs();
    endtask

    initial begin
        rst = 3'b111;
        clear_inputs();
        test_reset();
        test_ifu_read();
        test_round_robin();
        test_store();
        test_latency3();
        test_back_pressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_mem_arb.md
YSYX_23060203_MEM_ARB -- requirements
Module: ysyx_23060203_mem_arb

Interface
REQ-001 SHALL have parameter: LAT, default 0, extra wait cycles in ACCESS before the memory port is driven (0..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have IFU ports: ifu_req_valid in 1; ifu_req_ready out 1; ifu_addr in 32; ifu_resp_valid out 1; ifu_resp_ready in 1; ifu_rdata out 32.
REQ-005 SHALL have LSU ports: lsu_req_valid in 1; lsu_req_ready out 1; lsu_wen in 1 (1=store); lsu_func in 3 (load/store width code); lsu_addr in 32; lsu_wdata in 32; lsu_resp_valid out 1; lsu_resp_ready in 1; lsu_rdata out 32.
REQ-006 SHALL have memory-port outputs: mem_ren 1, mem_rfunc 3, mem_raddr 32, mem_wen 1, mem_wfunc 3, mem_waddr 32, mem_wdata 32; and input mem_rdata 32, which is combinational from mem_raddr/mem_ren within the same cycle; a write commits at the rising edge ending the mem_wen cycle.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS, RESP; exactly one transaction is outstanding at any time.
REQ-008 SHALL assert req_ready only in IDLE, and only for the requester granted that cycle; the other requester's ready is 0.
REQ-009 SHALL grant by round-robin: with both valid, grant the requester not served by the most recently completed transaction; after reset, LSU has priority.
REQ-010 SHALL, on handshake (valid&ready in IDLE), latch owner, addr, wen, func, wdata; go to ACCESS and load wait counter with LAT.
REQ-011 SHALL, in ACCESS with counter>0, decrement the counter and keep all mem_* enables at 0.
REQ-012 SHALL, in ACCESS with counter==0, drive the memory port for exactly one cycle, then go to RESP.
REQ-013 For a read access: mem_ren=1, mem_raddr=latched addr, mem_rfunc=latched func (IFU: fixed 3'b010, word); mem_rdata is captured into the response register.
REQ-014 For a write access: mem_wen=1, mem_waddr=latched addr, mem_wdata=latched wdata, mem_wfunc=latched func; the response register is loaded with 0.
REQ-015 SHALL drive all mem_* outputs to 0 outside the single access cycle.
REQ-016 SHALL, in RESP, assert resp_valid of the owner only, with rdata held stable from the captured register until resp_ready; non-owner resp_valid=0 and rdata=0.
REQ-017 SHALL, on resp_valid&resp_ready, return to IDLE the next cycle (no same-cycle new grant); the winner is recorded for round-robin.
REQ-018 Latency: accept at edge N -> access cycle N+1+LAT -> resp_valid from cycle N+2+LAT.
REQ-019 SHALL perform no alignment checking or data shifting; address and func pass through unchanged.
REQ-020 SHALL ignore request-side inputs in ACCESS and RESP; changes to them after handshake do not affect the transaction.

Reset
REQ-021 SHALL, while rst=1 at a rising edge, enter IDLE, clear counter and response register, set round-robin to LSU-first.
REQ-022 SHALL, during and after rst, hold all req_ready, resp_valid, mem_ren and mem_wen at 0 until IDLE is evaluated, with all data outputs 0.
REQ-023 SHALL abort any in-flight transaction on reset: no write is issued and no response is delivered.

Verification
REQ-024 LAT=0, IFU read addr 0x80000000, mem word 0x00000413, resp_ready=1 -> mem_ren one cycle after accept, ifu_resp_valid next cycle with rdata 0x00000413, then IDLE.
REQ-025 Both valid in the same IDLE cycle after reset -> LSU granted first; IFU granted on the following transaction; alternation on repeated contention.
REQ-026 LSU store func=byte, addr 0x80000100, wdata 0xA5 -> exactly one mem_wen cycle with mem_wfunc=byte; lsu_resp_valid with lsu_rdata=0.
REQ-027 LAT=3, LSU load -> mem_ren asserted exactly at accept+4 cycles, resp_valid at accept+5; enables 0 during wait cycles.
REQ-028 resp_ready held 0 for 5 cycles in RESP -> resp_valid and rdata stable; req_ready of both requesters 0 throughout.
REQ-029 rst pulsed during ACCESS (LAT=2) of a store -> mem_wen never asserted, no resp_valid, FSM in IDLE with LSU-first priority.
